matmul_mem_ctrl: RTL and testbench

MATMUL_MEM_CTRL -- requirements
Module: matmul_mem_ctrl

---
 rtl/matmul_mem_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_matmul_mem_ctrl.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_mem_ctrl.sv
// Memory-side controller for a tiled matmul engine.
// Routes host writes into the A/B BRAM banks, forwards engine addresses
// during compute, then drains the C row-banks as a valid/ready stream.
// Optional build macro MATMUL_MEM_CTRL_OR_MERGE_EN: each drain beat is the
// bitwise OR of every C bank slice for the row (BB_SIZE beats total) instead
// of the sequential per-bank drain (NUM_BANKS*BB_SIZE beats).
module matmul_mem_ctrl #(
    parameter int NUM_BANKS = 2,
    parameter int DWIDTH    = 16,
    parameter int BB_SIZE   = 8,
    parameter int AWIDTH    = 7,
    localparam int WW = BB_SIZE * DWIDTH,
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                        clk,
    input  logic                        reset_0,
    input  logic                        host_we,
    input  logic                        host_sel_b,
    input  logic [BW-1:0]               host_bank,
    input  logic [AWIDTH-1:0]           host_addr,
    input  logic [WW-1:0]               host_data,
    input  logic                        start,
    input  logic [NUM_BANKS*AWIDTH-1:0] eng_a_addr,
    input  logic [NUM_BANKS*AWIDTH-1:0] eng_b_addr,
    input  logic                        eng_done,
    output logic                        eng_start,
    output logic [NUM_BANKS*AWIDTH-1:0] bram_a_addr,
    output logic [NUM_BANKS*AWIDTH-1:0] bram_b_addr,
    output logic [NUM_BANKS-1:0]        bram_a_we,
    output logic [NUM_BANKS-1:0]        bram_b_we,
    output logic [WW-1:0]               bram_wdata,
    output logic [AWIDTH-1:0]           c_rd_addr,
    input  logic [NUM_BANKS*WW-1:0]     c_rd_data,
    output logic [WW-1:0]               out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done
);

    localparam int RW = (BB_SIZE > 1) ? $clog2(BB_SIZE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPUTE,
        S_DRAIN_RD,
        S_DRAIN_OUT,
        S_FINISH
    } state_t;

    state_t                        state_q, state_d;
    logic [RW-1:0]                 row_q, row_d;
    logic [BW-1:0]                 bank_q, bank_d;
    logic [NUM_BANKS*AWIDTH-1:0]   bram_a_addr_q, bram_b_addr_q;
    logic [NUM_BANKS-1:0]          bram_a_we_q, bram_b_we_q;
    logic [WW-1:0]                 bram_wdata_q;
    logic                          eng_start_q;
    logic [AWIDTH-1:0]             c_rd_addr_q;
    logic [WW-1:0]                 out_data_q;
    logic [WW-1:0]                 beat_data;
    logic                          last_row;
    logic                          host_bank_ok;

    assign last_row     = (row_q == RW'(BB_SIZE - 1));
    // A bank index beyond NUM_BANKS (possible when NUM_BANKS is not a power of two) drops the write.
    assign host_bank_ok = (32'(host_bank) < NUM_BANKS);

`ifdef MATMUL_MEM_CTRL_OR_MERGE_EN
    // Merge every bank's slice of the current row into one beat.
    always_comb begin
        beat_data = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            beat_data = beat_data | c_rd_data[k*WW +: WW];
        end
    end
`else
    assign beat_data = c_rd_data[bank_q*WW +: WW];
`endif

    // Next-state and drain row/bank counter logic.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        bank_d  = bank_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (eng_done) begin
                    state_d = S_DRAIN_RD;
                    row_d   = '0;
                    bank_d  = '0;
                end
            end
            S_DRAIN_RD: begin
                state_d = S_DRAIN_OUT;
            end
            S_DRAIN_OUT: begin
                if (out_ready) begin
                    if (last_row) begin
                        row_d = '0;
`ifdef MATMUL_MEM_CTRL_OR_MERGE_EN
                        state_d = S_FINISH;
`else
                        if (bank_q == BW'(NUM_BANKS - 1)) begin
                            state_d = S_FINISH;
                        end else begin
                            bank_d  = bank_q + 1'b1;
                            state_d = S_DRAIN_RD;
                        end
`endif
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = S_DRAIN_RD;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and drain counter registers.
    always_ff @(posedge clk) begin
        if (reset_0) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            bank_q  <= bank_d;
        end
    end

    // BRAM-side registers: host writes, engine address forwarding, drain capture.
    always_ff @(posedge clk) begin
        if (reset_0) begin
            bram_a_addr_q <= '0;
            bram_b_addr_q <= '0;
            bram_a_we_q   <= '0;
            bram_b_we_q   <= '0;
            bram_wdata_q  <= '0;
            eng_start_q   <= 1'b0;
            c_rd_addr_q   <= '0;
            out_data_q    <= '0;
        end else begin
            bram_a_we_q <= '0;
            bram_b_we_q <= '0;
            eng_start_q <= (state_q == S_IDLE) && start;
            case (state_q)
                S_IDLE: begin
                    if (host_we && host_bank_ok) begin
                        bram_wdata_q <= host_data;
                        if (host_sel_b) begin
                            bram_b_addr_q[host_bank*AWIDTH +: AWIDTH] <= host_addr;
                            bram_b_we_q[host_bank]                    <= 1'b1;
                        end else begin
                            bram_a_addr_q[host_bank*AWIDTH +: AWIDTH] <= host_addr;
                            bram_a_we_q[host_bank]                    <= 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    bram_a_addr_q <= eng_a_addr;
                    bram_b_addr_q <= eng_b_addr;
                end
                S_DRAIN_RD: begin
                    out_data_q <= beat_data;
                end
                default: ;
            endcase
            // Present the row address for the whole DRAIN_RD cycle so the data is ready at its end.
            if (state_d == S_DRAIN_RD) c_rd_addr_q <= AWIDTH'(row_d);
        end
    end

    assign eng_start   = eng_start_q;
    assign bram_a_addr = bram_a_addr_q;
    assign bram_b_addr = bram_b_addr_q;
    assign bram_a_we   = bram_a_we_q;
    assign bram_b_we   = bram_b_we_q;
    assign bram_wdata  = bram_wdata_q;
    assign c_rd_addr   = c_rd_addr_q;
    assign out_data    = out_data_q;
    assign out_valid   = (state_q == S_DRAIN_OUT);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FINISH);

endmodule

// File: tb/tb_matmul_mem_ctrl.sv
// Self-checking bench for matmul_mem_ctrl (NUM_BANKS=2, BB_SIZE=8, DWIDTH=16, AWIDTH=7),
// plus a NUM_BANKS=3 instance for out-of-range host bank writes.
module tb_matmul_mem_ctrl;

    localparam int NB = 2;
    localparam int DW = 16;
    localparam int BB = 8;
    localparam int AW = 7;
    localparam int WW = BB * DW;
`ifdef MATMUL_MEM_CTRL_OR_MERGE_EN
    localparam int NBEATS = BB;
`else
    localparam int NBEATS = NB * BB;
`endif

    logic              clk;
    logic              reset_0;
    logic              host_we;
    logic              host_sel_b;
    logic [0:0]        host_bank;
    logic [AW-1:0]     host_addr;
    logic [WW-1:0]     host_data;
    logic              start;
    logic [NB*AW-1:0]  eng_a_addr, eng_b_addr;
    logic              eng_done;
    logic              eng_start;
    logic [NB*AW-1:0]  bram_a_addr, bram_b_addr;
    logic [NB-1:0]     bram_a_we, bram_b_we;
    logic [WW-1:0]     bram_wdata;
    logic [AW-1:0]     c_rd_addr;
    logic [NB*WW-1:0]  c_rd_data;
    logic [WW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    // Three-bank instance signals
    logic              h3_we;
    logic [1:0]        h3_bank;
    logic [AW-1:0]     h3_addr;
    logic              z_start, z_done, z_ready;
    logic [3*AW-1:0]   z_eaddr;
    logic [3*WW-1:0]   z_cdata;
    logic              eng_start3, out_valid3, busy3, done3;
    logic [3*AW-1:0]   a_addr3, b_addr3;
    logic [2:0]        a_we3, b_we3;
    logic [WW-1:0]     wdata3, out_data3;
    logic [AW-1:0]     c_rd_addr3;

    int n_tests = 0;
    int n_fail  = 0;
    logic [WW-1:0] sb[$];

    matmul_mem_ctrl #(.NUM_BANKS(NB), .DWIDTH(DW), .BB_SIZE(BB), .AWIDTH(AW)) u_dut (
        .clk(clk), .reset_0(reset_0), .host_we(host_we), .host_sel_b(host_sel_b),
        .host_bank(host_bank), .host_addr(host_addr), .host_data(host_data),
        .start(start), .eng_a_addr(eng_a_addr), .eng_b_addr(eng_b_addr),
        .eng_done(eng_done), .eng_start(eng_start), .bram_a_addr(bram_a_addr),
        .bram_b_addr(bram_b_addr), .bram_a_we(bram_a_we), .bram_b_we(bram_b_we),
        .bram_wdata(bram_wdata), .c_rd_addr(c_rd_addr), .c_rd_data(c_rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    matmul_mem_ctrl #(.NUM_BANKS(3), .DWIDTH(DW), .BB_SIZE(BB), .AWIDTH(AW)) u_dut3 (
        .clk(clk), .reset_0(reset_0), .host_we(h3_we), .host_sel_b(1'b0),
        .host_bank(h3_bank), .host_addr(h3_addr), .host_data(host_data),
        .start(z_start), .eng_a_addr(z_eaddr), .eng_b_addr(z_eaddr),
        .eng_done(z_done), .eng_start(eng_start3), .bram_a_addr(a_addr3),
        .bram_b_addr(b_addr3), .bram_a_we(a_we3), .bram_b_we(b_we3),
        .bram_wdata(wdata3), .c_rd_addr(c_rd_addr3), .c_rd_data(z_cdata),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(z_ready),
        .busy(busy3), .done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // C row-bank contents: bank k, row r, lane j
    function automatic logic [WW-1:0] c_word(input int k, input int r);
        logic [WW-1:0] w;
        w = '0;
        for (int j = 0; j < BB; j++) begin
`ifdef MATMUL_MEM_CTRL_OR_MERGE_EN
            w[j*DW +: DW] = (k == 0) ? 16'h00F0 : 16'h0F00;
`else
            w[j*DW +: DW] = 16'(k * 256 + r * 16 + j);
`endif
        end
        return w;
    endfunction

    // C BRAM model: output register fed by the controller's registered c_rd_addr
    always_comb begin
        c_rd_data = '0;
        for (int k = 0; k < NB; k++) c_rd_data[k*WW +: WW] = c_word(k, int'(c_rd_addr));
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_expected();
`ifdef MATMUL_MEM_CTRL_OR_MERGE_EN
        for (int r = 0; r < BB; r++) sb.push_back(c_word(0, r) | c_word(1, r));
`else
        for (int k = 0; k < NB; k++)
            for (int r = 0; r < BB; r++) sb.push_back(c_word(k, r));
`endif
    endtask

    task automatic drain_loop(input bit check_tp, input int exp_beats);
        int beats = 0;
        int dones = 0;
        int last = -100;
        bit finished = 1'b0;
        bit saw_done = 1'b0;
        logic [WW-1:0] exp;
        for (int c = 0; c < 200 && !finished; c++) begin
            if (saw_done) begin
                n_tests++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_after_finish: got %0b expected 0", busy);
                end
                finished = 1'b1;
            end else begin
                if (done === 1'b1) begin
                    dones++;
                    saw_done = 1'b1;
                end
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_beat: got %0h expected no beat", out_data);
                    end else begin
                        exp = sb.pop_front();
                        if (out_data !== exp) begin
                            n_fail++;
                            $display("FAIL beat%0d_data: got %0h expected %0h", beats, out_data, exp);
                        end
                    end
                    if (check_tp && beats > 0) begin
                        n_tests++;
                        if (c - last != 2) begin
                            n_fail++;
                            $display("FAIL beat_spacing: got %0d expected 2", c - last);
                        end
                    end
                    last = c;
                    beats++;
                end
                tick();
            end
        end
        n_tests++;
        if (!finished) begin
            n_fail++;
            $display("FAIL drain_timeout: got no finish expected finish within 200 cycles");
        end
        n_tests++;
        if (beats != exp_beats) begin
            n_fail++;
            $display("FAIL beat_count: got %0d expected %0d", beats, exp_beats);
        end
        n_tests++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL done_pulses: got %0d expected 1", dones);
        end
    endtask

    task automatic test_reset();
        reset_0 = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({bram_a_addr, bram_b_addr, c_rd_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: got %0h expected 0", {bram_a_addr, bram_b_addr, c_rd_addr});
        end
        n_tests++;
        if ({bram_a_we, bram_b_we} !== '0) begin
            n_fail++;
            $display("FAIL reset_we: got %0h expected 0", {bram_a_we, bram_b_we});
        end
        n_tests++;
        if ({bram_wdata, out_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %0h expected 0", {bram_wdata, out_data});
        end
        n_tests++;
        if ({eng_start, out_valid, busy, done} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000", {eng_start, out_valid, busy, done});
        end
        reset_0 = 1'b0;
        tick();
    endtask

    task automatic test_host_write();
        host_we = 1'b1; host_sel_b = 1'b0; host_bank = 1'b1; host_addr = 7'd5; host_data = 128'hAB;
        tick();
        host_we = 1'b0;
        n_tests++;
        if (bram_a_we !== 2'b10) begin
            n_fail++;
            $display("FAIL a_we: got %b expected 10", bram_a_we);
        end
        n_tests++;
        if (bram_a_addr[13:7] !== 7'd5) begin
            n_fail++;
            $display("FAIL a_addr_bank1: got %0d expected 5", bram_a_addr[13:7]);
        end
        n_tests++;
        if (bram_wdata !== 128'hAB) begin
            n_fail++;
            $display("FAIL wdata: got %0h expected ab", bram_wdata);
        end
        n_tests++;
        if (bram_b_we !== 2'b00) begin
            n_fail++;
            $display("FAIL b_we_idle: got %b expected 00", bram_b_we);
        end
        tick();
        n_tests++;
        if (bram_a_we !== 2'b00) begin
            n_fail++;
            $display("FAIL a_we_one_cycle: got %b expected 00", bram_a_we);
        end
        host_we = 1'b1; host_sel_b = 1'b1; host_bank = 1'b0; host_addr = 7'd9; host_data = 128'h1234;
        tick();
        host_we = 1'b0;
        n_tests++;
        if ({bram_b_we, bram_a_we} !== 4'b0100) begin
            n_fail++;
            $display("FAIL b_write_we: got %b expected 0100", {bram_b_we, bram_a_we});
        end
        n_tests++;
        if (bram_b_addr[6:0] !== 7'd9 || bram_a_addr[13:7] !== 7'd5) begin
            n_fail++;
            $display("FAIL b_write_addr: got b0=%0d a1=%0d expected b0=9 a1=5", bram_b_addr[6:0], bram_a_addr[13:7]);
        end
        tick();
    endtask

    task automatic test_invalid_bank();
        h3_we = 1'b1; h3_bank = 2'd3; h3_addr = 7'd7;
        tick();
        h3_we = 1'b0;
        n_tests++;
        if ({a_we3, b_we3} !== 6'b0) begin
            n_fail++;
            $display("FAIL bank3_dropped: got %b expected 000000", {a_we3, b_we3});
        end
        h3_we = 1'b1; h3_bank = 2'd2;
        tick();
        h3_we = 1'b0;
        n_tests++;
        if (a_we3 !== 3'b100 || a_addr3[20:14] !== 7'd7) begin
            n_fail++;
            $display("FAIL bank2_write: got we=%b addr=%0d expected we=100 addr=7", a_we3, a_addr3[20:14]);
        end
        tick();
    endtask

    task automatic test_start_with_write();
        host_we = 1'b1; host_sel_b = 1'b0; host_bank = 1'b0; host_addr = 7'd3; host_data = 128'h55;
        start = 1'b1;
        n_tests++;
        if (eng_start !== 1'b0) begin
            n_fail++;
            $display("FAIL eng_start_early: got %0b expected 0", eng_start);
        end
        tick();
        host_we = 1'b0; start = 1'b0;
        n_tests++;
        if (bram_a_we !== 2'b01 || bram_wdata !== 128'h55) begin
            n_fail++;
            $display("FAIL write_with_start: got we=%b wdata=%0h expected we=01 wdata=55", bram_a_we, bram_wdata);
        end
        n_tests++;
        if (eng_start !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL eng_start_pulse: got start=%0b busy=%0b expected 1 1", eng_start, busy);
        end
        tick();
        n_tests++;
        if (eng_start !== 1'b0) begin
            n_fail++;
            $display("FAIL eng_start_width: got %0b expected 0", eng_start);
        end
    endtask

    task automatic test_compute();
        eng_a_addr = {7'd9, 7'd3}; eng_b_addr = {7'd4, 7'd6};
        host_we = 1'b1; host_sel_b = 1'b0; host_bank = 1'b1; start = 1'b1;
        tick();
        n_tests++;
        if (bram_a_addr !== {7'd9, 7'd3} || bram_b_addr !== {7'd4, 7'd6}) begin
            n_fail++;
            $display("FAIL compute_addr: got a=%0h b=%0h expected a=%0h b=%0h", bram_a_addr, bram_b_addr, {7'd9, 7'd3}, {7'd4, 7'd6});
        end
        n_tests++;
        if ({bram_a_we, bram_b_we, eng_start} !== 5'b0) begin
            n_fail++;
            $display("FAIL compute_ignore_host: got %b expected 00000", {bram_a_we, bram_b_we, eng_start});
        end
        host_we = 1'b0; start = 1'b0;
        eng_a_addr = {7'd1, 7'd2};
        n_tests++;
        if (bram_a_addr !== {7'd9, 7'd3}) begin
            n_fail++;
            $display("FAIL compute_delay: got %0h expected %0h", bram_a_addr, {7'd9, 7'd3});
        end
        tick();
        n_tests++;
        if (bram_a_addr !== {7'd1, 7'd2}) begin
            n_fail++;
            $display("FAIL compute_follow: got %0h expected %0h", bram_a_addr, {7'd1, 7'd2});
        end
    endtask

    task automatic test_drain();
        push_expected();
        eng_done = 1'b1; out_ready = 1'b1;
        tick();
        eng_done = 1'b0;
        drain_loop(1'b1, NBEATS);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [WW-1:0] d0;
        push_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
        eng_done = 1'b1; out_ready = 1'b0;
        tick();
        eng_done = 1'b0;
        for (int c = 0; c < 10 && out_valid !== 1'b1; c++) tick();
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first_valid: got %0b expected 1", out_valid);
        end
        d0 = out_data;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== d0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%0b d=%0h expected v=1 d=%0h", i, out_valid, out_data, d0);
            end
        end
        out_ready = 1'b1;
        drain_loop(1'b0, NBEATS);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        int beats = 0;
        bit hit = 1'b0;
        bit saw_done = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        eng_done = 1'b1; out_ready = 1'b1;
        tick();
        eng_done = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (out_valid === 1'b1) begin
                beats++;
                if (beats == 3) begin
                    reset_0 = 1'b1;
                    hit = 1'b1;
                end
            end
            tick();
        end
        reset_0 = 1'b0;
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL mid_drain_timeout: got %0d beats expected 3", beats);
        end
        n_tests++;
        if ({out_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_state: got v=%0b busy=%0b expected 0 0", out_valid, busy);
        end
        n_tests++;
        if ({c_rd_addr, out_data} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_regs: got %0h expected 0", {c_rd_addr, out_data});
        end
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1 || busy !== 1'b0) saw_done = 1'b1;
            tick();
        end
        n_tests++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL mid_reset_done: got done/busy activity expected none");
        end
        out_ready = 1'b0;
        sb.delete();
    endtask

    initial begin
        reset_0 = 1'b1; host_we = 1'b0; host_sel_b = 1'b0; host_bank = '0; host_addr = '0;
        host_data = '0; start = 1'b0; eng_a_addr = '0; eng_b_addr = '0; eng_done = 1'b0;
        out_ready = 1'b0;
        h3_we = 1'b0; h3_bank = '0; h3_addr = '0;
        z_start = 1'b0; z_done = 1'b0; z_ready = 1'b0; z_eaddr = '0; z_cdata = '0;
        @(negedge clk);
        test_reset();
        test_host_write();
        test_invalid_bank();
        test_start_with_write();
        test_compute();
        test_drain();
        test_backpressure();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
